// File: rtl/pwm_audio_pkg.sv
// Shared definitions for the PWM audio path: score word layout, sequencer
// state encoding and the score-word decode helpers.
package pwm_audio_pkg;

   localparam int END_BIT  = 15;
   localparam int NOTE_MSB = 14;
   localparam int NOTE_LSB = 8;
   localparam int DUR_MSB  = 7;
   localparam int DUR_LSB  = 0;

   localparam int NOTE_W = NOTE_MSB - NOTE_LSB + 1;
   localparam int DUR_W  = DUR_MSB - DUR_LSB + 1;

   localparam logic [NOTE_W-1:0] NOTE_REST = '0;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      LOAD,
      PLAY
   } seq_state_t;

   typedef struct packed {
      logic              is_end;
      logic [NOTE_W-1:0] note;
      logic [DUR_W-1:0]  dur;
   } score_entry_t;

   function automatic score_entry_t decode_entry(input logic [15:0] word);
      score_entry_t e;
      e.is_end = word[END_BIT];
      e.note   = word[NOTE_MSB:NOTE_LSB];
      e.dur    = word[DUR_MSB:DUR_LSB];
      return e;
   endfunction

   // A zero duration plays for one unit rather than being skipped.
   function automatic logic [DUR_W-1:0] eff_dur(input logic [DUR_W-1:0] dur);
      return (dur == '0) ? DUR_W'(1) : dur;
   endfunction

endpackage

// File: rtl/seq_tick_gen.sv
// Tempo timebase: a TICK_DIV prescaler feeding a unit counter that pulses
// once every (unit_len+1) ticks. Both restart from 0 on clear.
module seq_tick_gen #(
   parameter int unsigned TICK_DIV = 40_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       enable,
   input  logic [7:0] unit_len,
   output logic       unit_pulse
);

   localparam int unsigned PRE_W = $clog2(TICK_DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

   logic [PRE_W-1:0] pre_cnt;
   logic [7:0]       unit_cnt;
   logic             tick;

   assign tick       = enable && (pre_cnt == PRE_LAST);
   assign unit_pulse = tick && (unit_cnt == unit_len);

   // NOTE: registered state uses non-blocking assignments so every flop
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt  <= '0;
         unit_cnt <= '0;
      end else if (clear) begin
         pre_cnt  <= '0;
         unit_cnt <= '0;
      end else if (enable) begin
         pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
         if (tick) begin
            unit_cnt <= unit_pulse ? '0 : unit_cnt + 8'd1;
         end
      end
   end

endmodule

// File: rtl/pwm_note_sequencer.sv
// Score sequencer: walks the external score ROM and drives note/gate/strobe
// for the tone voice, holding the voice steady across fetch gaps.
module pwm_note_sequencer
   import pwm_audio_pkg::*;
#(
   parameter int unsigned CLOCK_FREQ = 40_000_000,
   parameter int unsigned TICK_DIV   = 40_000,
   parameter int unsigned ADDR_W     = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic              loop_en,
   input  logic [7:0]        tempo,
   output logic              rom_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [15:0]       rom_data,
   output logic [6:0]        note,
   output logic              gate,
   output logic              note_strobe,
   output logic              busy,
   output logic              done
);

   if (TICK_DIV < 2 || TICK_DIV > (1 << 20) || CLOCK_FREQ < TICK_DIV) begin : g_bad_cfg
      $error("pwm_note_sequencer: TICK_DIV must be 2..2^20 and not exceed CLOCK_FREQ");
   end

   seq_state_t   state, state_next;
   score_entry_t entry;
   logic [7:0]   dur_cnt;
   logic [7:0]   unit_len;
   logic         unit_pulse;

   logic         begin_run;
   logic         load_note;
   logic         advance;
   logic         restart;
   logic         finish;

   assign entry  = decode_entry(rom_data);
   assign rom_en = (state == FETCH);
   assign busy   = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // NOTE: every output of this block gets a default first, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      begin_run  = 1'b0;
      load_note  = 1'b0;
      advance    = 1'b0;
      restart    = 1'b0;
      finish     = 1'b0;
      if (stop) begin
         state_next = IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  state_next = FETCH;
                  begin_run  = 1'b1;
               end
            end
            FETCH: state_next = LOAD;
            LOAD: begin
               if (entry.is_end) begin
                  if (loop_en) begin
                     state_next = FETCH;
                     restart    = 1'b1;
                  end else begin
                     state_next = IDLE;
                     finish     = 1'b1;
                  end
               end else begin
                  state_next = PLAY;
                  load_note  = 1'b1;
               end
            end
            PLAY: begin
               if (unit_pulse && dur_cnt == 8'd1) begin
                  state_next = FETCH;
                  advance    = 1'b1;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_addr <= '0;
      end else if (begin_run || restart) begin
         rom_addr <= '0;
      end else if (advance) begin
         rom_addr <= rom_addr + 1'b1;
      end
   end

   // Voice outputs only change on a new entry, a stop or the end of the
   // score, so they hold through FETCH/LOAD between notes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         note        <= NOTE_REST;
         gate        <= 1'b0;
         note_strobe <= 1'b0;
         done        <= 1'b0;
         dur_cnt     <= '0;
         unit_len    <= '0;
      end else begin
         note_strobe <= load_note;
         done        <= finish;
         if (stop || finish) begin
            note <= NOTE_REST;
            gate <= 1'b0;
         end else if (load_note) begin
            note     <= entry.note;
            gate     <= (entry.note != NOTE_REST);
            dur_cnt  <= eff_dur(entry.dur);
            unit_len <= tempo;
         end else if (state == PLAY && unit_pulse) begin
            dur_cnt <= dur_cnt - 8'd1;
         end
      end
   end

   seq_tick_gen #(
      .TICK_DIV(TICK_DIV)
   ) u_tick_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (state != PLAY),
      .enable    (state == PLAY),
      .unit_len  (unit_len),
      .unit_pulse(unit_pulse)
   );

endmodule

// File: doc/pwm_note_sequencer.md
# pwm_note_sequencer

Score sequencer for the PWM audio path. It walks an external score ROM, decodes each entry into a note index and a duration, and drives the tone voice with note, gate and strobe at a programmable tempo. It sits between the top-level user inputs and the PWM tone generator. It is the block that decides what the voice plays and when.

## Interface
- `CLOCK_FREQ`, 40_000_000: system clock in Hz, for documentation and derivation only.
- `TICK_DIV`, 40_000: clocks per tempo tick (1 ms at 40 MHz). Legal range is 2 to 2^20.
- `ADDR_W`, 8: score ROM address width.
- `clk`, input, 1: system clock. One clock domain only.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `start`, input, 1: level input. It is accepted only in IDLE.
- `stop`, input, 1: level input. It aborts playback from any state.
- `loop_en`, input, 1: when set, an end marker restarts playback at address 0.
- `tempo`, input, 8: ticks per duration unit, minus 1.
- `rom_en`, output, 1: score ROM read strobe.
- `rom_addr`, output, ADDR_W: score ROM address.
- `rom_data`, input, 16: score word, valid 1 cycle after `rom_en`. Bit 15 is the end marker, bits 14:8 are the note (0 means rest), and bits 7:0 are the duration in units (0 is treated as 1).
- `note`, output, 7: current note index, passed to the voice.
- `gate`, output, 1: voice enable.
- `note_strobe`, output, 1: one-cycle pulse when a new note or rest begins.
- `busy`, output, 1: high in any state other than IDLE.
- `done`, output, 1: one-cycle pulse at the end of a non-looping score.

## Operation
- States:
  - IDLE to FETCH on `start`.
  - FETCH (drive `rom_en`) to LOAD.
  - LOAD (capture `rom_data`) to PLAY, or on the end marker to FETCH at address 0 (`loop_en`=1) or to IDLE with a `done` pulse (`loop_en`=0).
  - PLAY to FETCH at address+1 when the duration expires.
- `stop` high forces IDLE on the next edge from any state. It drops `gate`, clears `note`, and leaves `done` low. `stop` has priority over `start`.
- `start` is ignored while `busy`.
- The end marker consumes no play time, and its note and duration bits are ignored.
- If the score starts with an end marker and `loop_en`=1, the block fetches forever and never enters PLAY; this is legal.
- Entering PLAY:
  - `note` <= entry note.
  - `gate` <= (note != 0).
  - `note_strobe` is high for one cycle.
  - `tempo` is sampled into a unit-length register. Changing `tempo` mid-note has no effect until the next entry.
- In PLAY, the tick prescaler restarts at 0 on entry. A unit counter counts ticks up to the sampled tempo+1, and a duration counter counts units down to 0.
- During FETCH and LOAD between notes, `gate` and `note` hold their previous values, so the voice sounds continuously without glitches.
- `rom_addr` wraps from 2^ADDR_W-1 to 0 without an end marker.
- Counter widths:
  - Prescaler: clog2(TICK_DIV).
  - Unit counter: 8 bits.
  - Duration counter: 8 bits.
  - No overflow is possible.

## Timing
- Reset values: `rom_en`=0, `rom_addr`=0, `note`=0, `gate`=0, `note_strobe`=0, `busy`=0, `done`=0. State is IDLE.
- `start` sampled at edge E: FETCH in cycle E+1 (`rom_en`=1), LOAD in E+2, PLAY outputs visible in E+3.
- Entry PLAY lasts exactly max(dur,1)*(tempo+1)*TICK_DIV cycles, followed by 2 overhead cycles (FETCH, LOAD). The total per entry is therefore that value +2.
- `done` is asserted in the cycle after LOAD of a non-looping end marker. `busy` falls in that same cycle.
- If `stop` is sampled at edge E, then from E+1: `busy`=0, `gate`=0, `note`=0, `rom_en`=0.
- Reset asserted mid-operation clears all state immediately (asynchronous). Deassertion is synchronous to `clk` through the standard reset synchroniser upstream.

## Structure
- Shared package `pwm_audio_pkg`:
  - Score word field positions: END_BIT=15, NOTE_MSB/LSB=14/8, DUR_MSB/LSB=7/0.
  - State enum `seq_state_t` with values IDLE, FETCH, LOAD, PLAY.
  - NOTE_REST=0.
- Sub-module `seq_tick_gen`: the prescaler and unit counter. It takes synchronous clear and enable inputs and outputs `unit_pulse`.
- The FSM, duration counter and output registers stay in `pwm_note_sequencer`. The score ROM is external.

## Test plan
- Reset:
  - Stimulus: `TICK_DIV`=4; assert `rst_n`=0 mid-PLAY.
  - Expected: all outputs go to reset values without waiting for a clock edge; no `done` pulse.
- Basic play:
  - Stimulus: `TICK_DIV`=4, `tempo`=1; ROM = {note 60 dur 2, rest dur 1, END}, `loop_en`=0.
  - Expected: `note`=60 with `gate`=1 for 16 cycles; then `note`=0 with `gate`=0 for 8 cycles; `done` pulses once at address 2; exactly 2 `note_strobe` pulses.
- Duration zero:
  - Stimulus: entry note 5, dur 0, `tempo`=0, `TICK_DIV`=4.
  - Expected: PLAY lasts 4 cycles, the same as dur 1.
- Loop:
  - Stimulus: `loop_en`=1 with the same score.
  - Expected: `rom_addr` sequence 0,1,2,0,1,2…; `done` never asserted; `gate` stays high across the FETCH/LOAD boundary between repeated notes.
- Stop/start priority:
  - Stimulus: assert `start` and `stop` together in IDLE.
  - Expected: the block stays IDLE.
  - Stimulus: assert `stop` during LOAD.
  - Expected: IDLE on the next cycle; `gate`=0.
- Tempo change:
  - Stimulus: change `tempo` from 1 to 3 mid-note.
  - Expected: the current note keeps its 8-cycles-per-unit length; the next note uses 16 cycles per unit.
